analog_rbk: RTL and testbench
=============================

# analog_rbk

Readback engine for the analog Ising macro. It is the reader counterpart to the configuration write path. On a start pulse it asserts each J read word line one-hot in turn, then the h read word line. After a programmable settle time it samples the macro's read bit lines and packs PARALLELISM consecutive J rows into one digital J-memory word. It writes that word, and the h row, back through the memory write ports so software can verify or snapshot macro contents.

## Interface
- NUM_SPIN, 256, spins per row / number of J rows
- BITDATA, 4, bits per weight
- PARALLELISM, 1, J rows packed per memory word (min 1, divides NUM_SPIN)
- COUNTER_BITWIDTH, 16, width of timing counters
- J_ADDRESS_WIDTH, $clog2(NUM_SPIN/PARALLELISM), J memory address width
- clk_i  in  1  single clock
- rst_i  in  1  reset; asynchronous, active-high
- en_i  in  1  block enable; low aborts any readback
- cfg_configure_enable_i  in  1  load timing registers
- cycle_per_rwl_high_i  in  COUNTER_BITWIDTH  read word line high (settle) cycles
- cycle_per_rwl_low_i  in  COUNTER_BITWIDTH  read word line low (gap) cycles
- rbk_start_i  in  1  start pulse
- rbl_i  in  NUM_SPIN*BITDATA  read bit lines from macro
- j_one_hot_rwl_o  out  NUM_SPIN  one-hot J read word line
- h_rwl_o  out  1  h read word line
- j_mem_wen_o  out  1  J memory write strobe (1-cycle)
- j_waddr_o  out  J_ADDRESS_WIDTH  J memory write address
- j_wdata_o  out  NUM_SPIN*BITDATA*PARALLELISM  packed J word
- h_wen_o  out  1  h write strobe (1-cycle)
- h_wdata_o  out  NUM_SPIN*BITDATA  h row data
- rbk_idle_o  out  1  high when IDLE
- rbk_done_o  out  1  1-cycle pulse on normal completion

## Operation
- **Timing registers:**
  - H_reg and L_reg are loaded from the *_i ports when cfg_configure_enable_i=1 and state is IDLE.
  - Loads while busy are ignored.
  - A value of 0 is treated as 1.
- **States:** IDLE, HIGH, LOW.
- **IDLE:**
  - Transitions to HIGH when en_i & rbk_start_i.
  - Clears the row counter r to 0.
  - rbk_start_i outside IDLE is ignored.
- **HIGH:**
  - Drives the row r word line: j_one_hot_rwl_o = 1<<r for r<NUM_SPIN; h_rwl_o=1 for r==NUM_SPIN.
  - Lasts H_reg cycles.
  - On the clock edge ending the last HIGH cycle, rbl_i is captured.
  - For a J row, the capture goes into slice s=r%PARALLELISM of the j_wdata_o holding register, at bits [(s+1)*NUM_SPIN*BITDATA-1 -: NUM_SPIN*BITDATA].
  - For the h row, the capture goes into h_wdata_o.
  - Then the FSM moves to LOW.
- **LOW:**
  - All word lines are 0. Lasts L_reg cycles.
  - In the first LOW cycle:
    - j_mem_wen_o=1 with j_waddr_o=r/PARALLELISM if r is a J row and s==PARALLELISM-1.
    - h_wen_o=1 if r==NUM_SPIN.
  - At the end of LOW:
    - If r==NUM_SPIN: rbk_done_o pulses and the FSM goes to IDLE in the same edge.
    - Otherwise r increments and the FSM goes to HIGH.
- **Data hold:** j_wdata_o, h_wdata_o and j_waddr_o hold between strobes. Unwritten slices keep their previous value.
- **Abort (en_i=0 in any state):**
  - Next state is IDLE and word lines go to 0.
  - No write strobe and no done pulse are generated.
  - The data registers keep their values.
- **Row counter width:** r is $clog2(NUM_SPIN+1) bits and never wraps; the h row terminates the sequence.

## Timing
- **Reset values:**
  - All outputs are 0 except rbk_idle_o=1.
  - State is IDLE, counters and r are 0, H_reg=L_reg=1.
- **Start:**
  - The start is sampled at edge 0.
  - The word line for row 0 is high from cycle 1 and stays high for H cycles.
  - The row period is H+L cycles.
- **Write strobe:** a write strobe appears exactly H cycles after its row's word line rises.
- **Done:**
  - rbk_done_o is high in the last LOW cycle of the h row, i.e. cycle (NUM_SPIN+1)*(H+L) after start.
  - rbk_idle_o is high the following cycle.
- **Word line overlap:** word lines never overlap. At least one all-zero cycle separates consecutive rows (L≥1).
- **Back-to-back runs:** a start pulse on the first IDLE cycle after done is accepted.

## Structure
- Shared package analog_rbk_pkg holds:
  - typedef enum rbk_state_e {IDLE, HIGH, LOW};
  - helper function for slice index.
- One sub-module, analog_rbk_phase_counter:
  - loadable down-counter with async active-high reset;
  - outputs last_o (current phase ends this cycle);
  - instantiated once and reloaded with H_reg or L_reg at each phase entry.

## Test plan
Bench uses NUM_SPIN=8, BITDATA=4, PARALLELISM=2, H=3, L=2 unless noted. The macro model drives rbl_i = 32'h1111_1111*(row+1) while the word line is high.
- **Reset:** assert rst_i mid-HIGH of row 3 -> all outputs 0 immediately, rbk_idle_o=1, no strobe after release.
- **Full run:**
  - j_mem_wen_o at addresses 0,1,2,3 with j_wdata_o = {row(2a+1) pattern, row(2a) pattern}, e.g. addr0 = 64'h2222_2222_1111_1111.
  - h_wen_o with h_wdata_o=32'h9999_9999.
  - rbk_done_o at cycle 45 after start.
- **Zero timing:** H=0, L=0 loaded -> row period 2 cycles, done at cycle 18.
- **Abort:** drop en_i during HIGH of row 5 -> word lines 0 next cycle, no further strobes, no done, addr2 never written.
- **Busy ignores:** rbk_start_i and cfg_configure_enable_i with H=7 during row 2 -> sequence unchanged; H=7 applies on the next run.
- **PARALLELISM=1:** j_mem_wen_o every row, addresses 0..7 in order, j_wdata_o = that row's pattern.

Source files
------------

// File: rtl/analog_rbk_pkg.sv
// Shared types and helpers for the analog macro readback engine.
package analog_rbk_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} rbk_state_e;

  // Slice of the packed J word that a given row lands in.
  function automatic int unsigned slice_idx(int unsigned row, int unsigned par);
    return row % par;
  endfunction

endpackage

// File: rtl/analog_rbk_if.sv
// Control, macro and memory-write signals of the readback engine.
interface analog_rbk_if #(
  parameter int unsigned NUM_SPIN         = 256,
  parameter int unsigned BITDATA          = 4,
  parameter int unsigned PARALLELISM      = 1,
  parameter int unsigned COUNTER_BITWIDTH = 16,
  parameter int unsigned J_ADDRESS_WIDTH  = $clog2(NUM_SPIN / PARALLELISM)
);

  logic                                     en_i;
  logic                                     cfg_configure_enable_i;
  logic [COUNTER_BITWIDTH-1:0]              cycle_per_rwl_high_i;
  logic [COUNTER_BITWIDTH-1:0]              cycle_per_rwl_low_i;
  logic                                     rbk_start_i;
  logic [NUM_SPIN*BITDATA-1:0]              rbl_i;
  logic [NUM_SPIN-1:0]                      j_one_hot_rwl_o;
  logic                                     h_rwl_o;
  logic                                     j_mem_wen_o;
  logic [J_ADDRESS_WIDTH-1:0]               j_waddr_o;
  logic [NUM_SPIN*BITDATA*PARALLELISM-1:0]  j_wdata_o;
  logic                                     h_wen_o;
  logic [NUM_SPIN*BITDATA-1:0]              h_wdata_o;
  logic                                     rbk_idle_o;
  logic                                     rbk_done_o;

  modport master (
    output en_i, cfg_configure_enable_i, cycle_per_rwl_high_i, cycle_per_rwl_low_i,
    output rbk_start_i, rbl_i,
    input  j_one_hot_rwl_o, h_rwl_o, j_mem_wen_o, j_waddr_o, j_wdata_o,
    input  h_wen_o, h_wdata_o, rbk_idle_o, rbk_done_o
  );

  modport slave (
    input  en_i, cfg_configure_enable_i, cycle_per_rwl_high_i, cycle_per_rwl_low_i,
    input  rbk_start_i, rbl_i,
    output j_one_hot_rwl_o, h_rwl_o, j_mem_wen_o, j_waddr_o, j_wdata_o,
    output h_wen_o, h_wdata_o, rbk_idle_o, rbk_done_o
  );

endinterface

// File: rtl/analog_rbk_phase_counter.sv
// Loadable down-counter timing one word-line phase; last_o flags the final cycle.
module analog_rbk_phase_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/analog_rbk.sv
// Readback engine: walks J rows then the h row, samples the read bit lines
// after the settle time and writes packed words back to memory.
module analog_rbk
  import analog_rbk_pkg::*;
#(
  parameter int unsigned NUM_SPIN         = 256,
  parameter int unsigned BITDATA          = 4,
  parameter int unsigned PARALLELISM      = 1,
  parameter int unsigned COUNTER_BITWIDTH = 16,
  parameter int unsigned J_ADDRESS_WIDTH  = $clog2(NUM_SPIN / PARALLELISM)
) (
  input logic         clk_i,
  input logic         rst_i,
  analog_rbk_if.slave bus
);

  localparam int unsigned RowBits  = NUM_SPIN * BITDATA;
  localparam int unsigned RowWidth = $clog2(NUM_SPIN + 1);
  localparam logic [RowWidth-1:0] HRow = RowWidth'(NUM_SPIN);

  rbk_state_e                          state_q, state_d;
  logic [RowWidth-1:0]                 r_q, r_d;
  logic [COUNTER_BITWIDTH-1:0]         h_reg_q, l_reg_q, phase_len;
  logic                                phase_load, phase_last;
  logic                                capture, done;
  logic                                is_j_row, last_slice;
  int unsigned                         slice;
  logic                                j_wen_q, h_wen_q;
  logic [J_ADDRESS_WIDTH-1:0]          j_waddr_q;
  logic [RowBits*PARALLELISM-1:0]      j_wdata_q;
  logic [RowBits-1:0]                  h_wdata_q;

  // A programmed length of zero would never end a phase, so it means one cycle.
  function automatic logic [COUNTER_BITWIDTH-1:0] at_least_one(
    logic [COUNTER_BITWIDTH-1:0] v
  );
    return (v == '0) ? COUNTER_BITWIDTH'(1) : v;
  endfunction

  assign is_j_row   = (r_q != HRow);
  assign slice      = slice_idx(32'(r_q), PARALLELISM);
  assign last_slice = (slice == PARALLELISM - 1);

  analog_rbk_phase_counter #(
    .Width (COUNTER_BITWIDTH)
  ) u_phase_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (phase_load),
    .load_val_i (phase_len),
    .last_o     (phase_last)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    phase_load = 1'b0;
    phase_len  = h_reg_q;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        r_d = '0;
        if (bus.rbk_start_i) begin
          state_d    = HIGH;
          phase_load = 1'b1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_d    = LOW;
          phase_load = 1'b1;
          phase_len  = l_reg_q;
          capture    = 1'b1;
        end
      end
      LOW: begin
        if (phase_last) begin
          if (!is_j_row) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            r_d        = r_q + RowWidth'(1);
            state_d    = HIGH;
            phase_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything: no capture, no strobe, no done.
    if (!bus.en_i) begin
      state_d    = IDLE;
      phase_load = 1'b0;
      capture    = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      h_reg_q <= COUNTER_BITWIDTH'(1);
      l_reg_q <= COUNTER_BITWIDTH'(1);
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      if (bus.cfg_configure_enable_i && state_q == IDLE) begin
        h_reg_q <= at_least_one(bus.cycle_per_rwl_high_i);
        l_reg_q <= at_least_one(bus.cycle_per_rwl_low_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      j_wen_q   <= 1'b0;
      h_wen_q   <= 1'b0;
      j_waddr_q <= '0;
      j_wdata_q <= '0;
      h_wdata_q <= '0;
    end else begin
      j_wen_q <= capture && is_j_row && last_slice;
      h_wen_q <= capture && !is_j_row;
      if (capture && is_j_row) begin
        j_wdata_q[slice*RowBits +: RowBits] <= bus.rbl_i;
      end
      if (capture && is_j_row && last_slice) begin
        j_waddr_q <= J_ADDRESS_WIDTH'(32'(r_q) / PARALLELISM);
      end
      if (capture && !is_j_row) begin
        h_wdata_q <= bus.rbl_i;
      end
    end
  end

  assign bus.j_one_hot_rwl_o = (state_q == HIGH && is_j_row) ? (NUM_SPIN'(1) << r_q) : '0;
  assign bus.h_rwl_o         = (state_q == HIGH) && !is_j_row;
  assign bus.j_mem_wen_o     = j_wen_q;
  assign bus.j_waddr_o       = j_waddr_q;
  assign bus.j_wdata_o       = j_wdata_q;
  assign bus.h_wen_o         = h_wen_q;
  assign bus.h_wdata_o       = h_wdata_q;
  assign bus.rbk_idle_o      = (state_q == IDLE);
  assign bus.rbk_done_o      = done;

endmodule

// File: tb/tb_analog_rbk.sv
// Scoreboard bench: two engines (PARALLELISM 2 and 1) share stimulus and a macro model.
module tb_analog_rbk;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic        cfg;
  logic [15:0] hi;
  logic [15:0] lo;
  int          edges;
  int          base;
  int          n_checks;
  int          n_errors;

  typedef struct { int addr; logic [63:0] data; int cyc; } jexp_t;
  typedef struct { logic [31:0] data; int cyc; } hexp_t;

  jexp_t jq_a[$], jq_b[$];
  hexp_t hq_a[$], hq_b[$];
  int    dq_a[$], dq_b[$];

  analog_rbk_if #(.NUM_SPIN(8), .BITDATA(4), .PARALLELISM(2)) bus_a ();
  analog_rbk_if #(.NUM_SPIN(8), .BITDATA(4), .PARALLELISM(1)) bus_b ();

  analog_rbk #(.NUM_SPIN(8), .BITDATA(4), .PARALLELISM(2)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  analog_rbk #(.NUM_SPIN(8), .BITDATA(4), .PARALLELISM(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  function automatic logic [31:0] pat(int row);
    return 32'h1111_1111 * (row + 1);
  endfunction

  function automatic logic [31:0] macro_rbl(logic [7:0] wl, logic h);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (wl[i]) v = pat(i);
    if (h) v = pat(8);
    return v;
  endfunction

  assign bus_a.en_i                   = en;
  assign bus_a.rbk_start_i            = start;
  assign bus_a.cfg_configure_enable_i = cfg;
  assign bus_a.cycle_per_rwl_high_i   = hi;
  assign bus_a.cycle_per_rwl_low_i    = lo;
  assign bus_a.rbl_i = macro_rbl(bus_a.j_one_hot_rwl_o, bus_a.h_rwl_o);
  assign bus_b.en_i                   = en;
  assign bus_b.rbk_start_i            = start;
  assign bus_b.cfg_configure_enable_i = cfg;
  assign bus_b.cycle_per_rwl_high_i   = hi;
  assign bus_b.cycle_per_rwl_low_i    = lo;
  assign bus_b.rbl_i = macro_rbl(bus_b.j_one_hot_rwl_o, bus_b.h_rwl_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected traffic for a run whose first `rows` rows complete their capture.
  task automatic push_run(int h, int l, int rows);
    int he, le, per;
    jexp_t j;
    hexp_t hx;
    he  = (h == 0) ? 1 : h;
    le  = (l == 0) ? 1 : l;
    per = he + le;
    for (int r = 0; r < 8 && r < rows; r++) begin
      j.addr = r; j.data = {32'd0, pat(r)}; j.cyc = 1 + r * per + he;
      jq_b.push_back(j);
      if (r % 2 == 1) begin
        j.addr = r / 2; j.data = {pat(r), pat(r - 1)};
        jq_a.push_back(j);
      end
    end
    if (rows == 9) begin
      hx.data = pat(8); hx.cyc = 1 + 8 * per + he;
      hq_a.push_back(hx);
      hq_b.push_back(hx);
      dq_a.push_back(9 * per);
      dq_b.push_back(9 * per);
    end
  endtask

  always @(negedge clk) begin
    int c;
    jexp_t j;
    hexp_t hx;
    c = edges - base;
    if (!rst) begin
      check("a_wl_onehot", 64'($countones({bus_a.h_rwl_o, bus_a.j_one_hot_rwl_o}) <= 1), 1);
      if (bus_a.j_mem_wen_o) begin
        check("a_j_expected", 64'(jq_a.size() != 0), 1);
        if (jq_a.size() != 0) begin
          j = jq_a.pop_front();
          check("a_j_addr", 64'(bus_a.j_waddr_o), 64'(j.addr));
          check("a_j_data", bus_a.j_wdata_o, j.data);
          check("a_j_cycle", 64'(c), 64'(j.cyc));
        end
      end
      if (bus_a.h_wen_o) begin
        check("a_h_expected", 64'(hq_a.size() != 0), 1);
        if (hq_a.size() != 0) begin
          hx = hq_a.pop_front();
          check("a_h_data", 64'(bus_a.h_wdata_o), 64'(hx.data));
          check("a_h_cycle", 64'(c), 64'(hx.cyc));
        end
      end
      if (bus_a.rbk_done_o) begin
        check("a_done_expected", 64'(dq_a.size() != 0), 1);
        if (dq_a.size() != 0) check("a_done_cycle", 64'(c), 64'(dq_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    int c;
    jexp_t j;
    hexp_t hx;
    c = edges - base;
    if (!rst) begin
      check("b_wl_onehot", 64'($countones({bus_b.h_rwl_o, bus_b.j_one_hot_rwl_o}) <= 1), 1);
      if (bus_b.j_mem_wen_o) begin
        check("b_j_expected", 64'(jq_b.size() != 0), 1);
        if (jq_b.size() != 0) begin
          j = jq_b.pop_front();
          check("b_j_addr", 64'(bus_b.j_waddr_o), 64'(j.addr));
          check("b_j_data", 64'(bus_b.j_wdata_o), j.data);
          check("b_j_cycle", 64'(c), 64'(j.cyc));
        end
      end
      if (bus_b.h_wen_o) begin
        check("b_h_expected", 64'(hq_b.size() != 0), 1);
        if (hq_b.size() != 0) begin
          hx = hq_b.pop_front();
          check("b_h_data", 64'(bus_b.h_wdata_o), 64'(hx.data));
          check("b_h_cycle", 64'(c), 64'(hx.cyc));
        end
      end
      if (bus_b.rbk_done_o) begin
        check("b_done_expected", 64'(dq_b.size() != 0), 1);
        if (dq_b.size() != 0) check("b_done_cycle", 64'(c), 64'(dq_b.pop_front()));
      end
    end
  end

  function automatic int pending();
    return jq_a.size() + jq_b.size() + hq_a.size() + hq_b.size() + dq_a.size() + dq_b.size();
  endfunction

  // Start takes effect at the next edge; the cycle after it is cycle 1.
  task automatic start_now();
    start = 1'b1;
    base  = edges;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_now();
  endtask

  task automatic load_cfg(int h, int l);
    @(negedge clk);
    hi  = 16'(h);
    lo  = 16'(l);
    cfg = 1'b1;
    @(negedge clk);
    cfg = 1'b0;
  endtask

  task automatic wait_drain(int extra);
    int n;
    n = 0;
    while (pending() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 400), 1);
    repeat (extra) @(negedge clk);
    check("drain_empty", 64'(pending()), 0);
  endtask

  initial begin
    int n;
    edges = 0; base = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1; en = 1'b1; start = 1'b0; cfg = 1'b0; hi = 16'd3; lo = 16'd2;
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(bus_a.rbk_idle_o), 1);
    check("rst_wl", 64'({bus_a.h_rwl_o, bus_a.j_one_hot_rwl_o}), 0);
    check("rst_strobes", 64'({bus_a.j_mem_wen_o, bus_a.h_wen_o, bus_a.rbk_done_o}), 0);
    check("rst_jdata", bus_a.j_wdata_o, 0);
    check("rst_hdata", 64'(bus_a.h_wdata_o), 0);
    rst = 1'b0;

    // Full run, then a back-to-back run started on the first idle cycle.
    load_cfg(3, 2);
    push_run(3, 2, 9);
    pulse_start();
    n = 0;
    while (!bus_a.rbk_done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(n < 100), 1);
    push_run(3, 2, 9);
    @(negedge clk);
    check("idle_after_done", 64'(bus_a.rbk_idle_o), 1);
    start_now();
    wait_drain(3);

    // Start and configuration load during row 2 are ignored.
    push_run(3, 2, 9);
    pulse_start();
    repeat (10) @(negedge clk);
    hi = 16'd7; cfg = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg = 1'b0; start = 1'b0;
    wait_drain(3);

    load_cfg(7, 2);
    push_run(7, 2, 9);
    pulse_start();
    wait_drain(3);

    // Zero timing behaves as one cycle per phase.
    load_cfg(0, 0);
    push_run(0, 0, 9);
    pulse_start();
    wait_drain(3);

    // Abort during HIGH of row 5.
    load_cfg(3, 2);
    push_run(3, 2, 5);
    pulse_start();
    repeat (25) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_wl_a", 64'({bus_a.h_rwl_o, bus_a.j_one_hot_rwl_o}), 0);
    check("abort_wl_b", 64'({bus_b.h_rwl_o, bus_b.j_one_hot_rwl_o}), 0);
    check("abort_idle", 64'(bus_a.rbk_idle_o), 1);
    wait_drain(60);
    check("abort_hold_a_data", bus_a.j_wdata_o, {pat(3), pat(4)});
    check("abort_hold_a_addr", 64'(bus_a.j_waddr_o), 1);
    check("abort_hold_b_data", 64'(bus_b.j_wdata_o), 64'(pat(4)));
    check("abort_hold_b_addr", 64'(bus_b.j_waddr_o), 4);
    en = 1'b1;

    // Asynchronous reset mid-HIGH of row 3.
    push_run(3, 2, 3);
    pulse_start();
    repeat (16) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_wl", 64'({bus_a.h_rwl_o, bus_a.j_one_hot_rwl_o}), 0);
    check("arst_idle", 64'(bus_a.rbk_idle_o), 1);
    check("arst_jdata", bus_a.j_wdata_o, 0);
    check("arst_b_jdata", 64'(bus_b.j_wdata_o), 0);
    check("arst_waddr", 64'(bus_b.j_waddr_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
